mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the processor's 64 KiB byte-wide memory. It shares one single-port byte memory between the CPU memory port (port 0) and the program loader/debug port (port 1). Each 16-bit word access is split into two sequential byte cycles, little-endian: low byte at `a`, high byte at `a+1`. It sits between the CPU core, the loader, and the memory array, and replaces direct array indexing by the core.

## Interface
Parameters:
- `AW`, 16: address width; byte-addressed, memory size 2^AW bytes.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `m0_req`, in, 1: port 0 request.
- `m0_we`, in, 1: port 0 direction; 1 = write.
- `m0_word`, in, 1: port 0 size; 1 = 16-bit, 0 = 8-bit.
- `m0_addr`, in, AW: port 0 byte address.
- `m0_wdata`, in, 16: port 0 write data; only [7:0] used for byte accesses.
- `m0_ack`, out, 1: port 0 completion pulse, one cycle.
- `m0_rdata`, out, 16: port 0 read data, valid while `m0_ack` is high.
- `m1_req`, `m1_we`, `m1_word`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: identical set for port 1.
- `mem_en`, out, 1: memory cycle enable.
- `mem_we`, out, 1: memory write strobe; qualified by `mem_en`.
- `mem_addr`, out, AW: memory byte address.
- `mem_wdata`, out, 8: memory write byte.
- `mem_rdata`, in, 8: memory read byte; synchronous, valid the cycle after `mem_en=1, mem_we=0`.
- `busy`, out, 1: high in every state except IDLE.
- `owner`, out, 1: port currently or last served.

## Operation
- **FSM states:** IDLE, A0, A1, FIN.
- **IDLE:**
  - `req` is sampled only in IDLE.
  - If any `req` is high, pick the winner and latch its `we`, `word`, `addr` and `wdata`.
  - Set `owner` to the winner and go to A0.
- **A0:**
  - `mem_en=1`, `mem_we=we`, `mem_addr=addr`, `mem_wdata=wdata[7:0]`.
  - Go to A1 if `word`, else to FIN.
- **A1 (word only):**
  - `mem_en=1`, `mem_addr=addr+1`, `mem_wdata=wdata[15:8]`.
  - Address increment is modulo 2^AW: 0xFFFF+1 wraps to 0x0000.
  - On a read, capture `mem_rdata` (the A0 byte) into `rdata[7:0]`.
  - Go to FIN.
- **FIN:**
  - `mem_en=0`.
  - On a read, capture `mem_rdata`: into `rdata[15:8]` for a word, or into `rdata[7:0]` with `[15:8]=0` for a byte.
  - Assert the owner's `ack` for this one cycle. The other port's `ack` stays 0.
  - Go to IDLE.
- **Arbitration:** round-robin.
  - If only one port requests, it wins.
  - If both request, the port not equal to `owner` wins.
  - `owner` resets to 1, so port 0 wins the first contention.
- **Requester rules:**
  - Hold `req` and all fields stable from assertion until the `ack` cycle.
  - Deassert `req` at the edge ending the `ack` cycle, or keep it high with new fields to issue the next access.
  - If `req` drops before `ack`, the access still completes and `ack` still pulses.
- **Write acks:** `rdata` holds its previous value.
- `mem_we=0` whenever `mem_en=0`.

## Timing
- **Reset (async, `rst=0`):**
  - State goes to IDLE; `owner=1`.
  - `m0_ack`, `m1_ack`, `mem_en`, `mem_we`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `m0_rdata`, `m1_rdata` = 0.
- **Reset mid-access:** the access is abandoned with no `ack`. A word write reset in A1 may leave only the low byte written; that is acceptable.
- **Latency:** with `req` sampled in IDLE at cycle N:
  - A0 is cycle N+1.
  - Byte access: `ack` at cycle N+2.
  - Word access: A1 at N+2, `ack` at N+3.
- **Throughput:** one access per 3 cycles (byte) or 4 cycles (word). IDLE always costs one cycle between accesses.
- **Pending requests:** a request arriving while `busy=1` waits; it is sampled at the next IDLE.

## Test plan
- **Byte write then read, port 0:** write 0xA5 to 0x0010 (byte), then byte-read 0x0010.
  - Write: `mem_en`/`mem_we` high one cycle, with addr 0x0010 and data 0xA5.
  - Read: `m0_ack` at N+2 with `m0_rdata=0x00A5`.
- **Word write/read with wrap, port 1:** write 0x1234 at 0xFFFF.
  - Memory sees 0x34 at 0xFFFF, then 0x12 at 0x0000.
  - A word read of 0xFFFF returns 0x1234 with `ack` at N+3.
- **Simultaneous word reads from both ports after reset:**
  - Port 0 is served first, port 1 second.
  - With both held high, grants alternate 0,1,0,1.
  - `ack`s are spaced by 4 cycles.
- **Late-arriving request:** port 1 raises `req` while port 0's word access is in A0.
  - Port 1 waits.
  - Its A0 starts at the second cycle after `m0_ack` (FIN, IDLE, A0).
- **Back-to-back single requester:** port 0 keeps `req` high for three byte writes to addresses 0x20, 0x21, 0x22.
  - Three `ack` pulses at a 3-cycle spacing.
  - Port 1 is never acked.
- **Reset during A1 of a word write:**
  - All outputs go to 0 immediately and no `ack` is issued.
  - The next request after reset release is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port byte memory; words go out as two byte cycles, little-endian.
// Latency: request sampled in IDLE at N -> A0 at N+1, ack at N+2 (byte) or N+3 (word); one IDLE cycle between accesses.
// Backpressure: requests are only sampled in IDLE; a requester holds req and fields stable until its one-cycle ack.
module mem_arbiter #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_word,
  input  logic [AW-1:0] m0_addr,
  input  logic [15:0]   m0_wdata,
  output logic          m0_ack,
  output logic [15:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_word,
  input  logic [AW-1:0] m1_addr,
  input  logic [15:0]   m1_wdata,
  output logic          m1_ack,
  output logic [15:0]   m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, A0, A1, FIN} state_t;

  state_t        state, state_nxt;
  logic          cur_we, cur_word;
  logic [AW-1:0] cur_addr;
  logic [15:0]   cur_wdata;
  logic [7:0]    lo_byte;
  logic [15:0]   rdata0_q, rdata1_q;
  logic [15:0]   fin_rdata;
  logic          any_req, win;

  // Only one requester wins outright; on contention the port that was not served last goes next.
  assign any_req = m0_req | m1_req;
  assign win     = (m0_req & m1_req) ? ~owner : m1_req;

  // The byte arriving in FIN is the high byte of a word (low byte kept from A1) or the whole byte read.
  assign fin_rdata = cur_word ? {mem_rdata, lo_byte} : {8'h00, mem_rdata};

  // Read data goes straight through during a read ack so it is valid in the ack cycle; otherwise held.
  assign m0_rdata = (m0_ack && !cur_we) ? fin_rdata : rdata0_q;
  assign m1_rdata = (m1_ack && !cur_we) ? fin_rdata : rdata1_q;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and memory-side/ack outputs; A0 drives the low byte, A1 the high byte at addr+1 (wrapping).
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cur_addr;
    mem_wdata = cur_wdata[7:0];
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = A0;
      A0: begin
        mem_en    = 1'b1;
        mem_we    = cur_we;
        state_nxt = cur_word ? A1 : FIN;
      end
      A1: begin
        mem_en    = 1'b1;
        mem_we    = cur_we;
        mem_addr  = cur_addr + AW'(1);
        mem_wdata = cur_wdata[15:8];
        state_nxt = FIN;
      end
      FIN: begin
        m0_ack    = ~owner;
        m1_ack    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's access in IDLE, collect read bytes in A1 and FIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= 1'b1;
      cur_we    <= 1'b0;
      cur_word  <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      lo_byte   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= win;
        cur_we    <= win ? m1_we    : m0_we;
        cur_word  <= win ? m1_word  : m0_word;
        cur_addr  <= win ? m1_addr  : m0_addr;
        cur_wdata <= win ? m1_wdata : m0_wdata;
      end
      if (state == A1 && !cur_we) lo_byte <= mem_rdata;
      if (state == FIN && !cur_we) begin
        if (owner) rdata1_q <= fin_rdata;
        else       rdata0_q <= fin_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks and memory writes, monitors pop and compare.
// A behavioural synchronous byte memory sits on the memory port.
// Ack timing is checked against the cycle counter value computed when each access is issued.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req[2], we[2], word[2];
  logic [15:0] addr[2], wdata[2];
  logic        ack0, ack1;
  logic [15:0] rd0, rd1;
  logic        mem_en, mem_we, busy, owner;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic        port;
    logic [15:0] rdata;
    logic [31:0] cyc;
  } exp_t;
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t        sbq[$];
  wr_t         wrq[$];
  logic [15:0] last_rd[2];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_word(word[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack0), .m0_rdata(rd0),
    .m1_req(req[1]), .m1_we(we[1]), .m1_word(word[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack1), .m1_rdata(rd1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

  // Cycle counter and synchronous byte memory.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Ack and memory-write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (rst === 1'b1) begin
      if (ack0 || ack1) begin
        chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        if (sbq.size() == 0) fail("unexpected_ack");
        else begin
          e = sbq.pop_front();
          chk("ack_port", 32'(ack1), 32'(e.port));
          chk("ack_cycle", 32'(cyc), e.cyc);
          chk("ack_rdata", 32'(ack1 ? rd1 : rd0), 32'(e.rdata));
        end
      end
      if (mem_we && !mem_en) fail("mem_we_without_en");
      if (mem_en && mem_we) begin
        if (wrq.size() == 0) fail("unexpected_mem_write");
        else begin
          w = wrq.pop_front();
          chk("mem_wr_addr", 32'(mem_addr), 32'(w.a));
          chk("mem_wr_data", 32'(mem_wdata), 32'(w.d));
        end
      end
    end
  end

  task automatic expect_acc(input int p, input logic w, input logic wd, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] rdexp, input int ack_cyc);
    exp_t e;
    wr_t  m;
    if (!w) last_rd[p] = rdexp;
    e.port  = (p == 1);
    e.rdata = last_rd[p];
    e.cyc   = 32'(ack_cyc);
    sbq.push_back(e);
    if (w) begin
      m.a = a;
      m.d = d[7:0];
      wrq.push_back(m);
      if (wd) begin
        m.a = a + 16'd1;
        m.d = d[15:8];
        wrq.push_back(m);
      end
    end
  endtask

  task automatic drive(input int p, input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d);
    we[p]    = w;
    word[p]  = wd;
    addr[p]  = a;
    wdata[p] = d;
    req[p]   = 1'b1;
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One access from an idle arbiter; req drops at the edge ending the ack cycle.
  task automatic single(input int p, input logic w, input logic wd, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] rdexp);
    int c;
    c = cyc;
    expect_acc(p, w, wd, a, d, rdexp, c + (wd ? 3 : 2));
    drive(p, w, wd, a, d);
    at_cyc(c + (wd ? 4 : 3));
    req[p] = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_m0_ack"}, 32'(ack0), 32'd0);
    chk({tag, "_m1_ack"}, 32'(ack1), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd1);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_m0_rdata"}, 32'(rd0), 32'd0);
    chk({tag, "_m1_rdata"}, 32'(rd1), 32'd0);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
  endtask

  initial begin
    int c;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; word[p] = 1'b0; addr[p] = 16'h0; wdata[p] = 16'h0;
      last_rd[p] = 16'h0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst0");
    rst = 1'b1;
    @(posedge clk); #1;

    // Byte write then read, port 0.
    single(0, 1'b1, 1'b0, 16'h0010, 16'h00A5, 16'h0000);
    single(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00A5);
    // Word write and read wrapping from 0xFFFF to 0x0000, port 1.
    single(1, 1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000);
    single(1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234);
    chk("owner_after_p1", 32'(owner), 32'd1);

    // Fresh reset, then both ports hold word reads: grants 0,1,0,1 with 4-cycle ack spacing.
    rst = 1'b0;
    #1;
    reset_checks("rst1");
    rst = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    expect_acc(0, 1'b0, 1'b1, 16'h0010, 16'h0, 16'h00A5, c + 3);
    expect_acc(1, 1'b0, 1'b1, 16'hFFFF, 16'h0, 16'h1234, c + 7);
    expect_acc(0, 1'b0, 1'b1, 16'h0010, 16'h0, 16'h00A5, c + 11);
    expect_acc(1, 1'b0, 1'b1, 16'hFFFF, 16'h0, 16'h1234, c + 15);
    drive(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
    drive(1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    at_cyc(c + 12);
    req[0] = 1'b0;
    at_cyc(c + 16);
    req[1] = 1'b0;

    // Port 1 arrives while port 0's word read is in A0; it waits for FIN and IDLE.
    c = cyc;
    expect_acc(0, 1'b0, 1'b1, 16'h0010, 16'h0, 16'h00A5, c + 3);
    drive(0, 1'b0, 1'b1, 16'h0010, 16'h0000);
    at_cyc(c + 1);
    chk("late_busy_in_a0", 32'(busy), 32'd1);
    chk("late_owner_in_a0", 32'(owner), 32'd0);
    expect_acc(1, 1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h0034, c + 6);
    drive(1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
    at_cyc(c + 4);
    req[0] = 1'b0;
    at_cyc(c + 7);
    req[1] = 1'b0;

    // Back-to-back byte writes with req held high, acks 3 cycles apart.
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      expect_acc(0, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'(8'h11 * (i + 1)), 16'h0, c + 3 * i + 2);
      drive(0, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'(8'h11 * (i + 1)));
      at_cyc(c + 3 * i + 3);
    end
    req[0] = 1'b0;
    single(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h2211);
    single(1, 1'b0, 1'b0, 16'h0022, 16'h0000, 16'h0033);

    // Reset during A1 of a word write: only the low byte lands, no ack.
    c = cyc;
    begin
      wr_t m;
      m.a = 16'h0300;
      m.d = 8'hEF;
      wrq.push_back(m);
    end
    drive(1, 1'b1, 1'b1, 16'h0300, 16'hBEEF);
    at_cyc(c + 2);
    chk("a1_mem_addr", 32'(mem_addr), 32'h0301);
    chk("a1_mem_wdata", 32'(mem_wdata), 32'hBE);
    #2 rst = 1'b0;
    #1;
    reset_checks("rst2");
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    single(0, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h00EF);

    repeat (4) @(posedge clk);
    #1;
    chk("acks_outstanding", 32'(sbq.size()), 32'd0);
    chk("mem_writes_outstanding", 32'(wrq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
